// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Purpose  : Eight-way round-robin arbiter with one-hot registered grant and
//            a hold-time limit that forces release of a long-running holder.
//            Sits between the requester bank and the shared datapath select.
// Ports    : clk          rising-edge clock
//            rst          synchronous active-high reset
//            req[7:0]     level-sensitive request vector (bit i = requester i)
//            done         current holder releases (ignored when idle)
//            grant[7:0]   registered one-hot grant, zero when idle
//            grant_idx    binary index of the holder, 0 when idle
//            grant_valid  high while a grant is active
//            timeout      one-cycle pulse after a forced release
// Params   : MAX_HOLD     maximum grant length in cycles (must be >= 2)
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int                 c_cnt_w   = $clog2(MAX_HOLD);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_HOLD - 1);

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_grant = 1'b1;

    // 3-to-8 one-hot decode of a binary index.
    function automatic logic [7:0] f_decode3to8(input logic [2:0] sel);
        f_decode3to8 = 8'b0000_0001 << sel;
    endfunction

    logic [0:0]         r_state;
    logic [2:0]         r_ptr;
    logic [c_cnt_w-1:0] r_cnt;
    logic [7:0]         r_grant;
    logic [2:0]         r_idx;
    logic               r_valid;
    logic               r_timeout;

    logic [0:0]         w_next_state;
    logic [2:0]         w_next_ptr;
    logic [c_cnt_w-1:0] w_next_cnt;
    logic [7:0]         w_next_grant;
    logic [2:0]         w_next_idx;
    logic               w_next_valid;
    logic               w_next_timeout;

    logic [2:0]         w_base;
    logic [7:0]         w_rot;
    logic [2:0]         w_off;
    logic               w_found;
    logic [2:0]         w_win;
    logic               w_forced;
    logic               w_release;

    // While holding, the only arbitration that matters is the one on release,
    // and that one must already use the advanced pointer (holder + 1), so the
    // search base is chosen here rather than waiting for r_ptr to update.
    assign w_base = (r_state == c_grant) ? (r_idx + 3'd1) : r_ptr;

    // Rotate so the highest-priority requester lands at bit 0.
    assign w_rot = 8'({req, req} >> w_base);

    // Lowest set bit of the rotated vector wins; descending scan leaves the
    // lowest index as the final assignment.
    always_comb begin
        w_found = 1'b0;
        w_off   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = 3'(i);
            end
        end
    end

    assign w_win     = w_base + w_off;
    assign w_forced  = (r_cnt == c_cnt_max);
    assign w_release = done | ~req[r_idx] | w_forced;

    // Next-state and next-output logic.
    always_comb begin
        w_next_state   = r_state;
        w_next_ptr     = r_ptr;
        w_next_cnt     = r_cnt;
        w_next_idx     = r_idx;
        w_next_valid   = r_valid;
        w_next_timeout = 1'b0;

        case (r_state)
            c_idle: begin
                if (w_found) begin
                    w_next_state = c_grant;
                    w_next_idx   = w_win;
                    w_next_valid = 1'b1;
                    w_next_cnt   = '0;
                end
            end
            c_grant: begin
                if (w_release) begin
                    w_next_ptr     = r_idx + 3'd1;
                    w_next_cnt     = '0;
                    // done takes precedence: a simultaneous done is a normal release.
                    w_next_timeout = w_forced & ~done;
                    if (w_found) begin
                        w_next_idx = w_win;
                    end else begin
                        w_next_state = c_idle;
                        w_next_idx   = 3'd0;
                        w_next_valid = 1'b0;
                    end
                end else begin
                    w_next_cnt = r_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_next_state = c_idle;
                w_next_idx   = 3'd0;
                w_next_valid = 1'b0;
            end
        endcase

        w_next_grant = w_next_valid ? f_decode3to8(w_next_idx) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_ptr     <= 3'd0;
            r_cnt     <= '0;
            r_grant   <= 8'h00;
            r_idx     <= 3'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_ptr     <= w_next_ptr;
            r_cnt     <= w_next_cnt;
            r_grant   <= w_next_grant;
            r_idx     <= w_next_idx;
            r_valid   <= w_next_valid;
            r_timeout <= w_next_timeout;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_idx;
    assign grant_valid = r_valid;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one downstream resource between eight requesters and drives the one-hot select lines that enable it. The winner is held as a 3-bit index and expanded to a one-hot grant through the team's 3-to-8 decode function. A hold-time limit forces release of a requester that holds the resource too long. The block sits between the requester bank and the shared datapath select.

## Interface
- MAX_HOLD, default 16: maximum grant length in cycles. Must be ≥ 2. The hold counter width is $clog2(MAX_HOLD).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i is requester i. Level-sensitive.
- done  input  1  the current holder releases the resource. Ignored when grant_valid=0.
- grant  output  8  one-hot grant, registered. All-zero when no grant is active.
- grant_idx  output  3  binary index of the holder; 0 when grant_valid=0.
- grant_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse marking a forced release.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one requester holds the resource.
- Internal state:
  - ptr[2:0]: the highest-priority index.
  - hold_cnt: the hold counter.
- Arbitration (combinational):
  - Search req starting at ptr, ascending, wrapping 7→0.
  - The first set bit wins.
- IDLE:
  - If req≠0: load the winner into grant_idx, set grant=decode(winner) and grant_valid=1, clear hold_cnt, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: a release condition occurs on any of:
  - (a) done=1;
  - (b) req[grant_idx]=0;
  - (c) hold_cnt==MAX_HOLD-1, which is a forced release.
- GRANT with no release condition: increment hold_cnt and hold grant unchanged.
- GRANT on release:
  - Set ptr=grant_idx+1 (mod 8).
  - Arbitrate immediately with the updated ptr.
  - If a winner exists, grant it at the next edge with no idle cycle and clear hold_cnt; stay in GRANT.
  - If there is no winner, go to IDLE with grant=0, grant_idx=0, grant_valid=0.
- Re-grant: the releasing requester can win again only if no other req bit is set and its own req is still high.
- Release precedence: if done and the forced-release condition are both true in the same cycle, the release counts as done and timeout stays 0.
- timeout: registered. It is 1 for exactly the cycle after the edge that applied a forced release, and 0 otherwise.
- Requests arriving or dropping for non-holders during GRANT have no effect until the next arbitration.
- Invariant: grant is always either zero or one-hot and equals decode(grant_idx) whenever grant_valid=1.

## Timing
- Reset values: grant=0, grant_idx=0, grant_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
- Reset asserted mid-grant clears all outputs at that edge. Priority restarts at requester 0.
- Request-to-grant latency: req sampled high at edge N gives grant visible after edge N (1 cycle).
- Release-to-next-grant: the release condition sampled at edge N switches grant to the next holder at edge N. No bubble cycle.
- Maximum grant length is MAX_HOLD consecutive cycles of grant_valid for one holder.
- Fairness: with all eight requesting continuously, each holder is served once per eight grants, in ascending order.

## Test plan
1. Reset mid-operation: assert rst while requester 5 holds the grant → after that edge grant=0, grant_valid=0, timeout=0; the next all-ones req grants index 0.
2. Single requester: req=8'h08 from IDLE → one cycle later grant=8'h08, grant_idx=3, grant_valid=1; pulse done → grant=0, grant_valid=0 the next cycle.
3. Full contention: req=8'hFF held, done pulsed each cycle of a grant → grant_idx sequence 0,1,2,…,7,0 with no idle cycles between grants.
4. Timeout with MAX_HOLD=4: req=8'h81, no done → index 0 holds for exactly 4 cycles; then grant=8'h80 and timeout=1 for one cycle; index 7 then times out and grant returns to index 0.
5. Holder drop and sole re-grant:
   - req=8'h24 with index 2 holding; drop req[2] → grant switches to 8'h20 next cycle, timeout=0.
   - Sole requester 5 asserts done with req[5] still high → re-granted to 5, hold_cnt restarts.
6. Simultaneous done and forced release: with MAX_HOLD=4, assert done in the 4th grant cycle → release occurs, timeout stays 0, and the next requester is granted.
